// File: rtl/car_pkg.sv
// Shared constants and types for the drawbridge occupancy counter.
package car_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage : car_pkg

// File: rtl/sync_rise_det.sv
// Synchronises one asynchronous sensor level into clk and flags its 0->1 transitions.
module sync_rise_det #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= w_sync_out;
    end
  end

  // One-cycle pulse per synchronised rising edge, however long the sensor stays high.
  assign o_rise = w_sync_out & ~r_hist;

endmodule : sync_rise_det

// File: rtl/car_counter.sv
// Saturating up/down count of cars on the span, with occupancy flag and sticky error.
module car_counter #(
  parameter int unsigned CNT_W       = car_pkg::CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CarIn,
  input  logic             CarOut,
  output logic             ExistCar,
  output logic [CNT_W-1:0] Count,
  output logic             Error
);

  localparam logic [CNT_W-1:0] CNT_FULL = '1;

  logic             w_in_rise;
  logic             w_out_rise;
  logic [CNT_W-1:0] r_count;
  logic             r_error;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_error_nxt;

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_in_det (
    .clk    (Clk),
    .rst_n  (Reset),
    .i_async(CarIn),
    .o_rise (w_in_rise)
  );

  sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_out_det (
    .clk    (Clk),
    .rst_n  (Reset),
    .i_async(CarOut),
    .o_rise (w_out_rise)
  );

  // Simultaneous entry and exit cancel out: count and error both untouched.
  always_comb begin
    w_count_nxt = r_count;
    w_error_nxt = r_error;
    unique case ({w_in_rise, w_out_rise})
      2'b10: begin
        if (r_count == CNT_FULL) w_error_nxt = 1'b1;
        else                     w_count_nxt = r_count + 1'b1;
      end
      2'b01: begin
        if (r_count == '0) w_error_nxt = 1'b1;
        else               w_count_nxt = r_count - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_error <= w_error_nxt;
    end
  end

  assign Count    = r_count;
  assign ExistCar = (r_count != '0);
  assign Error    = r_error;

endmodule : car_counter

// File: tb/tb_car_counter.sv
// Scoreboard bench for car_counter: default-width instance plus a 2-bit instance for saturation.
module tb_car_counter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CarIn, CarOut, CarIn2, CarOut2;
  logic       ExistCar, Error, ExistCar2, Error2;
  logic [7:0] Count;
  logic [1:0] Count2;

  car_counter dut (
    .Clk(Clk), .Reset(Reset), .CarIn(CarIn), .CarOut(CarOut),
    .ExistCar(ExistCar), .Count(Count), .Error(Error)
  );

  car_counter #(.CNT_W(2), .SYNC_STAGES(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .CarIn(CarIn2), .CarOut(CarOut2),
    .ExistCar(ExistCar2), .Count(Count2), .Error(Error2)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    bit    sel;
    int    cnt;
    bit    ex;
    bit    err;
    string tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_at(input int dly, input bit sel, input int cnt,
                           input bit ex, input bit err, input string tag);
    exp_t e;
    e.due = cyc + dly; e.sel = sel; e.cnt = cnt; e.ex = ex; e.err = err; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Pulse of 1 cycle high, 2 low; result is visible 3 tb cycles after the drive.
  task automatic pulse(input bit sel, input bit is_in, input int cnt,
                       input bit ex, input bit err, input string tag);
    expect_at(3, sel, cnt, ex, err, tag);
    if (sel) begin
      if (is_in) CarIn2 = 1'b1; else CarOut2 = 1'b1;
    end else begin
      if (is_in) CarIn = 1'b1; else CarOut = 1'b1;
    end
    step(1);
    CarIn = 1'b0; CarOut = 1'b0; CarIn2 = 1'b0; CarOut2 = 1'b0;
    step(2);
  endtask

  // Monitor: also wakes on reset assertion so the asynchronous clear is observed mid-cycle.
  initial begin
    exp_t e;
    int   act_cnt;
    bit   act_ex, act_err;
    forever begin
      @(negedge Clk or negedge Reset);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        act_cnt = e.sel ? int'(Count2) : int'(Count);
        act_ex  = e.sel ? ExistCar2 : ExistCar;
        act_err = e.sel ? Error2 : Error;
        if (e.due != cyc || act_cnt != e.cnt || act_ex != e.ex || act_err != e.err) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d: got cnt=%0d ex=%0b err=%0b, want cnt=%0d ex=%0b err=%0b",
                   e.tag, cyc, e.due, act_cnt, act_ex, act_err, e.cnt, e.ex, e.err);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0;
    CarIn = 1'b0; CarOut = 1'b0; CarIn2 = 1'b0; CarOut2 = 1'b0;

    // 1: reset, then idle
    step(1);
    expect_at(0, 0, 0, 0, 0, "rst_hold");
    expect_at(0, 1, 0, 0, 0, "rst_hold2");
    step(1);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      expect_at(0, 0, 0, 0, 0, "idle");
    end

    // 2: long CarIn, then long CarOut; exactly one count each
    CarIn = 1'b1;
    expect_at(2, 0, 0, 0, 0, "in_lat_early");
    expect_at(3, 0, 1, 1, 0, "in_lat");
    step(3);
    CarIn = 1'b0;
    step(4);
    expect_at(0, 0, 1, 1, 0, "in_held_once");
    CarOut = 1'b1;
    expect_at(2, 0, 1, 1, 0, "out_lat_early");
    expect_at(3, 0, 0, 0, 0, "out_lat");
    step(3);
    CarOut = 1'b0;
    step(4);
    expect_at(0, 0, 0, 0, 0, "out_held_once");

    // 3: three in, two out, one out
    pulse(0, 1, 1, 1, 0, "p_in1");
    pulse(0, 1, 2, 1, 0, "p_in2");
    pulse(0, 1, 3, 1, 0, "p_in3");
    pulse(0, 0, 2, 1, 0, "p_out1");
    pulse(0, 0, 1, 1, 0, "p_out2");
    pulse(0, 0, 0, 0, 0, "p_out3");
    step(2);

    // 4: simultaneous entry and exit at Count=2
    pulse(0, 1, 1, 1, 0, "p_in_a");
    pulse(0, 1, 2, 1, 0, "p_in_b");
    step(2);
    CarIn = 1'b1; CarOut = 1'b1;
    expect_at(3, 0, 2, 1, 0, "both");
    step(1);
    CarIn = 1'b0; CarOut = 1'b0;
    step(4);
    expect_at(0, 0, 2, 1, 0, "both_after");

    // 6: async reset mid-cycle with a CarIn edge in flight
    CarIn = 1'b1;
    step(1);
    #2;
    expect_at(0, 0, 0, 0, 0, "async_rst");
    Reset = 1'b0;
    CarIn = 1'b0;
    step(2);
    Reset = 1'b1;
    step(5);
    expect_at(0, 0, 0, 0, 0, "edge_lost");

    // 5a: underflow is sticky
    pulse(0, 0, 0, 0, 1, "underflow");
    step(6);
    expect_at(0, 0, 0, 0, 1, "err_sticky");
    pulse(0, 1, 1, 1, 1, "in_after_err");

    // 5b: 2-bit counter saturates at 3
    pulse(1, 1, 1, 1, 0, "sat1");
    pulse(1, 1, 2, 1, 0, "sat2");
    pulse(1, 1, 3, 1, 0, "sat3");
    pulse(1, 1, 3, 1, 1, "sat4");
    pulse(1, 1, 3, 1, 1, "sat5");
    pulse(1, 0, 2, 1, 1, "sat_out");
    step(3);

    for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_car_counter
